// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC and runs one outstanding req/gnt/rvalid transaction to instruction memory.
// Latency is 3 cycles per instruction with a zero-wait memory. StallF holds the presented instruction. PCSrcE redirects the fetch.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF,
  output logic        FetchStall
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] target;
  logic        unused_tgt;

  assign target     = {PCTargetE[31:2], 2'b00};
  assign unused_tgt = ^PCTargetE[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) state_d = PCSrcE ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (PCSrcE) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
            instr_d = imem_rdata;
            valid_d = 1'b1;
          end
        end else if (PCSrcE) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        // A redirect discards the held instruction even while downstream is stalled.
        if (PCSrcE || !StallF) begin
          state_d = S_REQ;
          instr_d = 32'h0;
          valid_d = 1'b0;
          if (!PCSrcE) pc_d = pc_q + 32'd4;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (PCSrcE) pc_d = target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = pc_q;
  assign InstrF     = instr_q;
  assign ValidF     = valid_q;
  assign FetchStall = (state_q != S_HOLD);
  assign PCF        = pc_q;
  assign PCPlus4F   = pc_q + 32'd4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized run against a transaction-level model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        ValidF, FetchStall;

  int vectors = 0;
  int miscompares = 0;

  // Model: PC, whether an instruction is held, whether a granted request is in flight and whether it is obsolete.
  logic [31:0] m_pc, m_instr;
  bit          m_started, m_have, m_inflight, m_stale;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF), .FetchStall(FetchStall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0;
    m_started = 0; m_have = 0; m_inflight = 0; m_stale = 0;
  endtask

  task automatic model_edge(input bit redir, input logic [31:0] tgt, input bit stall,
                            input bit gnt, input bit rv, input logic [31:0] rd);
    bit req_now, resp_now;
    logic [31:0] dest;
    dest = tgt & 32'hFFFF_FFFC;
    if (!m_started) begin
      m_started = 1;
      if (redir) m_pc = dest;
      return;
    end
    req_now  = !m_have && !m_inflight;
    resp_now = m_inflight && rv;
    if (redir) begin
      m_pc = dest;
      m_have = 0;
      if (req_now && gnt) begin m_inflight = 1; m_stale = 1; end
      else if (resp_now) m_inflight = 0;
      else if (m_inflight) m_stale = 1;
    end else if (m_have) begin
      if (!stall) begin m_have = 0; m_pc = m_pc + 32'd4; end
    end else if (req_now && gnt) begin
      m_inflight = 1; m_stale = 0;
    end else if (resp_now) begin
      m_inflight = 0;
      if (!m_stale) begin m_have = 1; m_instr = rd; end
    end
  endtask

  task automatic step(input bit redir, input logic [31:0] tgt, input bit stall,
                      input bit gnt, input bit rv, input logic [31:0] rd);
    PCSrcE = redir; PCTargetE = tgt; StallF = stall;
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
    @(posedge clk);
    model_edge(redir, tgt, stall, gnt, rv, rd);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    PCSrcE = 0; StallF = 0; imem_gnt = 0; imem_rvalid = 0; PCTargetE = 0; imem_rdata = 0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || ValidF !== 1'b0 || InstrF !== 32'h0 || FetchStall !== 1'b1 ||
        PCF !== 32'h0 || PCPlus4F !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b valid=%b instr=%h stall=%b pc=%h pc4=%h, expected 0 0 0 1 0 4",
               imem_req, ValidF, InstrF, FetchStall, PCF, PCPlus4F);
    end
  endtask

  task automatic test_first_fetch();
    apply_reset();
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL first_req: got req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
    step(0, 0, 0, 1, 0, 0);
    vectors++;
    if (imem_req !== 1'b0 || ValidF !== 1'b0) begin
      miscompares++;
      $display("FAIL first_wait: got req=%b valid=%b, expected 0 0", imem_req, ValidF);
    end
    step(0, 0, 0, 0, 1, 32'h0050_0093);
    vectors++;
    if (ValidF !== 1'b1 || InstrF !== 32'h0050_0093 || PCF !== 32'h0 || PCPlus4F !== 32'h4 || FetchStall !== 1'b0) begin
      miscompares++;
      $display("FAIL first_hold: got valid=%b instr=%h pc=%h pc4=%h stall=%b, expected 1 00500093 0 4 0",
               ValidF, InstrF, PCF, PCPlus4F, FetchStall);
    end
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || ValidF !== 1'b0 || InstrF !== 32'h0) begin
      miscompares++;
      $display("FAIL second_req: got req=%b addr=%h valid=%b instr=%h, expected 1 4 0 0",
               imem_req, imem_addr, ValidF, InstrF);
    end
  endtask

  task automatic test_stall();
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0010_0113);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 32'h1111_1111);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 0);
      vectors++;
      if (ValidF !== 1'b1 || InstrF !== 32'h1111_1111 || PCF !== 32'h8 || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got valid=%b instr=%h pc=%h req=%b, expected 1 11111111 8 0",
                 i, ValidF, InstrF, PCF, imem_req);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC || PCF !== 32'hC) begin
      miscompares++;
      $display("FAIL stall_release: got req=%b addr=%h pc=%h, expected 1 c c", imem_req, imem_addr, PCF);
    end
  endtask

  task automatic test_redirect_wait();
    step(0, 0, 0, 1, 0, 0);
    step(1, 32'h0000_0102, 0, 0, 0, 0);
    vectors++;
    if (imem_req !== 1'b0 || ValidF !== 1'b0 || PCF !== 32'h100) begin
      miscompares++;
      $display("FAIL redir_wait_drop: got req=%b valid=%b pc=%h, expected 0 0 100", imem_req, ValidF, PCF);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || ValidF !== 1'b0 || InstrF !== 32'h0) begin
      miscompares++;
      $display("FAIL redir_wait_reissue: got req=%b addr=%h valid=%b instr=%h, expected 1 100 0 0",
               imem_req, imem_addr, ValidF, InstrF);
    end
  endtask

  task automatic test_redirect_gnt();
    step(1, 32'h0000_0200, 0, 1, 0, 0);
    vectors++;
    if (imem_req !== 1'b0 || ValidF !== 1'b0 || PCF !== 32'h200) begin
      miscompares++;
      $display("FAIL redir_gnt_drop: got req=%b valid=%b pc=%h, expected 0 0 200", imem_req, ValidF, PCF);
    end
    step(0, 0, 0, 0, 1, 32'hCAFE_F00D);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || ValidF !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_gnt_reissue: got req=%b addr=%h valid=%b, expected 1 200 0", imem_req, imem_addr, ValidF);
    end
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 32'h00A0_0113);
    vectors++;
    if (ValidF !== 1'b1 || InstrF !== 32'h00A0_0113 || PCF !== 32'h200) begin
      miscompares++;
      $display("FAIL redir_gnt_fetch: got valid=%b instr=%h pc=%h, expected 1 00a00113 200", ValidF, InstrF, PCF);
    end
  endtask

  task automatic test_redirect_hold();
    step(1, 32'h0000_0300, 1, 0, 0, 0);
    vectors++;
    if (ValidF !== 1'b0 || FetchStall !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h300 || InstrF !== 32'h0) begin
      miscompares++;
      $display("FAIL redir_hold: got valid=%b fstall=%b req=%b addr=%h instr=%h, expected 0 1 1 300 0",
               ValidF, FetchStall, imem_req, imem_addr, InstrF);
    end
  endtask

  task automatic test_wrap();
    step(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_req: got req=%b addr=%h, expected 1 fffffffc", imem_req, imem_addr);
    end
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 32'h0000_0013);
    vectors++;
    if (ValidF !== 1'b1 || PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_hold: got valid=%b pc=%h pc4=%h, expected 1 fffffffc 0", ValidF, PCF, PCPlus4F);
    end
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || PCF !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_next: got req=%b addr=%h pc=%h, expected 1 0 0", imem_req, imem_addr, PCF);
    end
  endtask

  task automatic test_reset_in_wait();
    step(1, 32'h0000_0040, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    vectors++;
    if (PCF !== 32'h40 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_wait: got pc=%h req=%b, expected 40 0", PCF, imem_req);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || ValidF !== 1'b0 || InstrF !== 32'h0 || FetchStall !== 1'b1 ||
        PCF !== 32'h0 || PCPlus4F !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_in_wait: got req=%b valid=%b instr=%h stall=%b pc=%h pc4=%h, expected 0 0 0 1 0 4",
               imem_req, ValidF, InstrF, FetchStall, PCF, PCPlus4F);
    end
  endtask

  task automatic test_random();
    bit          mem_pend, redir, stall, gnt, rv, e_req, e_valid;
    logic [31:0] mem_addr, tgt, rd, e_instr;
    int          mem_delay;
    apply_reset();
    mem_pend = 0; mem_delay = 0; mem_addr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      e_req   = m_started && !m_have && !m_inflight;
      e_valid = m_have;
      e_instr = m_have ? m_instr : 32'h0;
      vectors++;
      if (imem_req !== e_req || (e_req && imem_addr !== m_pc) || ValidF !== e_valid || InstrF !== e_instr ||
          FetchStall !== !e_valid || PCF !== m_pc || PCPlus4F !== m_pc + 32'd4) begin
        miscompares++;
        $display("FAIL random[%0d]: got req=%b addr=%h valid=%b instr=%h fstall=%b pc=%h pc4=%h, expected req=%b addr=%h valid=%b instr=%h fstall=%b pc=%h pc4=%h",
                 cyc, imem_req, imem_addr, ValidF, InstrF, FetchStall, PCF, PCPlus4F,
                 e_req, m_pc, e_valid, e_instr, !e_valid, m_pc, m_pc + 32'd4);
      end
      redir = ($urandom_range(0, 9) == 0);
      tgt   = $urandom;
      stall = ($urandom_range(0, 2) == 0);
      gnt   = !mem_pend && ($urandom_range(0, 1) == 1);
      rv    = mem_pend && (mem_delay == 0);
      rd    = rv ? mem_word(mem_addr) : $urandom;
      step(redir, tgt, stall, gnt, rv, rd);
      if (rv) mem_pend = 0;
      else if (mem_pend && mem_delay > 0) mem_delay--;
      if (e_req && gnt) begin
        mem_pend  = 1;
        mem_addr  = m_pc;
        mem_delay = $urandom_range(0, 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_redirect_hold();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-stage producer for the IF/ID pipeline register. Drives InstrF, PCF and PCPlus4F into the IF/ID register.
- Owns the program counter and runs a single-outstanding request/grant/response handshake to instruction memory.
- Honours downstream stalls (StallF) and EX-stage branch/jump redirects (PCSrcE).
- While no valid instruction is held, presents a zero bubble and raises FetchStall so the hazard unit can stall or flush downstream.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- StallF  in  1  1 = downstream not accepting; hold the presented instruction.
- PCSrcE  in  1  1 = redirect fetch to PCTargetE this cycle.
- PCTargetE  in  32  redirect target; bits [1:0] are ignored and treated as 00.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  request word address; equals pc_q while imem_req is high.
- imem_gnt  in  1  memory accepts the request this cycle (valid only while imem_req=1).
- imem_rvalid  in  1  response data valid; at most one per granted request, 1 or more cycles after gnt.
- imem_rdata  in  32  response instruction.
- InstrF  out  32  instruction to IF/ID; 32'h0 when ValidF=0.
- PCF  out  32  PC of the presented instruction (pc_q).
- PCPlus4F  out  32  pc_q + 4, modulo 2^32.
- ValidF  out  1  InstrF holds a fetched instruction.
- FetchStall  out  1  equals !ValidF.

Behaviour:
- State: pc_q[31:0], instr_buf[31:0], FSM with states IDLE, REQ, WAIT, HOLD, DROP.
- Reset (reset=0, asynchronous):
  - pc_q = RESET_PC, instr_buf = 0, state = IDLE.
  - Outputs: imem_req=0, ValidF=0, InstrF=0, FetchStall=1, PCF=RESET_PC, PCPlus4F=RESET_PC+4.
  - Asserting reset mid-transaction abandons it; any later imem_rvalid for that transaction is the memory's responsibility to suppress.
- IDLE: go to REQ on the first clk after reset deasserts.
- REQ: imem_req=1, imem_addr=pc_q. Address is held stable until grant. On imem_gnt, go to WAIT.
- WAIT: imem_req=0. On imem_rvalid, capture instr_buf=imem_rdata and go to HOLD.
- HOLD: ValidF=1, InstrF=instr_buf.
  - If StallF=0, the instruction is consumed this edge (IF/ID captures it): pc_q <= pc_q+4, go to REQ.
  - If StallF=1, stay in HOLD with all outputs unchanged.
- DROP: waiting for a response to a request made obsolete by a redirect. imem_req=0. On imem_rvalid, discard the data and go to REQ.
- Redirect (PCSrcE=1) has priority over StallF and consume. In every state it sets pc_q <= {PCTargetE[31:2],2'b00}. State transitions on redirect:
  - IDLE -> REQ.
  - REQ without gnt -> REQ (new address next cycle).
  - REQ with gnt same cycle -> DROP.
  - WAIT without rvalid -> DROP.
  - WAIT with rvalid same cycle -> REQ (data discarded, buffer not loaded).
  - HOLD -> REQ (buffered instruction dropped, ValidF=0 next cycle, regardless of StallF).
  - DROP -> DROP (target updated, still waiting for the stale response).
- Minimum latency with a zero-wait memory (gnt in REQ cycle, rvalid the cycle after): 3 cycles per instruction, REQ->WAIT->HOLD.
- ValidF and InstrF are registered outputs. FetchStall is combinational from state.
- pc_q+4 wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- imem_gnt is ignored outside REQ. imem_rvalid is ignored outside WAIT and DROP.

Test Plan:
- Reset release, RESET_PC=0, memory grants immediately and responds next cycle with 32'h00500093, StallF=0 -> imem_req high at cycle 1 with imem_addr=0; ValidF=1, InstrF=32'h00500093, PCF=0, PCPlus4F=4 at cycle 3; next request imem_addr=4.
- StallF=1 held 4 cycles while in HOLD at PCF=8 -> InstrF/PCF/ValidF constant, no imem_req; StallF=0 -> pc advances to 12 and a request for 12 is issued.
- PCSrcE=1, PCTargetE=32'h0000_0102 during WAIT with rvalid 2 cycles later (rdata 32'hDEADBEEF) -> enters DROP, 32'hDEADBEEF never appears on InstrF, next request imem_addr=32'h0000_0100.
- Redirect in the same cycle as gnt in REQ -> DROP; stale response discarded; next request at the target; ValidF stays 0 throughout.
- Redirect in HOLD with StallF=1 -> ValidF=0 next cycle, FetchStall=1, request to the target issued.
- pc_q=32'hFFFF_FFFC consumed -> PCPlus4F=0; next imem_addr=0. Assert reset in WAIT -> outputs return to reset values immediately.
